sens_frame_progress: RTL and testbench

SENS_FRAME_PROGRESS -- requirements
Module: sens_frame_progress

---
 rtl/sens_frame_progress_pkg.sv | 14 +
 rtl/sens_frame_progress.sv | 113 +++++++++++
 tb/tb_sens_frame_progress.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sens_frame_progress_pkg.sv
// Shared sensor/compressor definitions: frame-progress state encoding and the
// width of the saturating broken-frame counter.
package sens_frame_progress_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } fp_state_e;

  localparam int BROKEN_CNT_W = 8;

endpackage

// File: rtl/sens_frame_progress.sv
// Tracks sensor frame writing into memory: line progress, frame buffer number,
// delayed vsync for the compressor and detection of frames cut short by a new start.
module sens_frame_progress
  import sens_frame_progress_pkg::*;
#(
  parameter int FRAME_HEIGHT_BITS = 16,
  parameter int LAST_FRAME_BITS   = 16
) (
  input  logic                         mclk,
  input  logic                         mrst,
  input  logic                         en,
  input  logic                         single_frame_buf,
  input  logic                         frame_start,
  input  logic                         line_done,
  input  logic [FRAME_HEIGHT_BITS-1:0] frame_height,
  input  logic [FRAME_HEIGHT_BITS-1:0] vsync_delay,
  input  logic [LAST_FRAME_BITS-1:0]   last_frame_number,
  output logic [FRAME_HEIGHT_BITS-1:0] line_unfinished,
  output logic [LAST_FRAME_BITS-1:0]   frame_number,
  output logic                         frame_done,
  output logic                         vsync_late,
  output logic                         frame_busy,
  output logic                         broken_frame,
  output logic [BROKEN_CNT_W-1:0]      broken_count
);

  fp_state_e                    state_q;
  logic [FRAME_HEIGHT_BITS-1:0] line_q, height_q, vtgt_q;
  logic [LAST_FRAME_BITS-1:0]   fnum_q;
  logic                         done_q, vsync_q, broken_q;
  logic                         first_q;  // no frame accepted yet since en rose
  logic [BROKEN_CNT_W-1:0]      bcnt_q;

  logic [FRAME_HEIGHT_BITS-1:0] line_d, vtgt_d;
  logic [LAST_FRAME_BITS-1:0]   fnum_d;

  // vsync fires when the line index reaches this target, clipped to the frame
  always_comb begin
    line_d = line_q + FRAME_HEIGHT_BITS'(1);
    vtgt_d = (vsync_delay < frame_height) ? vsync_delay : frame_height;
    fnum_d = fnum_q + LAST_FRAME_BITS'(1);
    if (single_frame_buf || first_q || (fnum_q >= last_frame_number))
      fnum_d = '0;
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      state_q  <= ST_IDLE;
      line_q   <= '0;
      height_q <= '0;
      vtgt_q   <= '0;
      fnum_q   <= '0;
      done_q   <= 1'b0;
      vsync_q  <= 1'b0;
      broken_q <= 1'b0;
      first_q  <= 1'b0;
      bcnt_q   <= '0;
    end else if (!en) begin
      state_q  <= ST_IDLE;
      line_q   <= '0;
      fnum_q   <= '0;
      done_q   <= 1'b0;
      vsync_q  <= 1'b0;
      broken_q <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      done_q   <= 1'b0;
      vsync_q  <= 1'b0;
      broken_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        state_q <= ST_READY;
        bcnt_q  <= '0;
        first_q <= 1'b1;
      end else if (frame_start) begin
        // accepted in READY, DONE and ACTIVE; in ACTIVE the old frame is dropped
        state_q  <= ST_ACTIVE;
        line_q   <= '0;
        height_q <= frame_height;
        vtgt_q   <= vtgt_d;
        vsync_q  <= (vtgt_d == '0);
        fnum_q   <= fnum_d;
        first_q  <= 1'b0;
        if (state_q == ST_ACTIVE) begin
          broken_q <= 1'b1;
          if (bcnt_q != '1) bcnt_q <= bcnt_q + BROKEN_CNT_W'(1);
        end
      end else begin
        case (state_q)
          ST_ACTIVE: begin
            if (line_q == height_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (line_done) begin
              line_q  <= line_d;
              vsync_q <= (line_d == vtgt_q);
            end
          end
          ST_DONE: state_q <= ST_READY;
          default: ;
        endcase
      end
    end
  end

  assign line_unfinished = line_q;
  assign frame_number    = fnum_q;
  assign frame_done      = done_q;
  assign vsync_late      = vsync_q;
  assign broken_frame    = broken_q;
  assign broken_count    = bcnt_q;
  assign frame_busy      = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_sens_frame_progress.sv
// Scoreboard bench for sens_frame_progress: each driven cycle queues the
// outputs expected after the next edge; a monitor pops and compares them.
module tb_sens_frame_progress;
  localparam int FHB = 16;
  localparam int LFB = 16;

  logic           mclk = 1'b0;
  logic           mrst = 1'b1, en = 1'b0, sfb = 1'b0, frame_start = 1'b0, line_done = 1'b0;
  logic [FHB-1:0] frame_height = '0, vsync_delay = '0;
  logic [LFB-1:0] last_frame_number = LFB'(2);
  logic [FHB-1:0] line_unfinished;
  logic [LFB-1:0] frame_number;
  logic           frame_done, vsync_late, frame_busy, broken_frame;
  logic [7:0]     broken_count;

  sens_frame_progress #(.FRAME_HEIGHT_BITS(FHB), .LAST_FRAME_BITS(LFB)) dut (
    .mclk(mclk), .mrst(mrst), .en(en), .single_frame_buf(sfb),
    .frame_start(frame_start), .line_done(line_done),
    .frame_height(frame_height), .vsync_delay(vsync_delay),
    .last_frame_number(last_frame_number),
    .line_unfinished(line_unfinished), .frame_number(frame_number),
    .frame_done(frame_done), .vsync_late(vsync_late), .frame_busy(frame_busy),
    .broken_frame(broken_frame), .broken_count(broken_count)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [31:0] line, fnum, bcnt;
    logic        done, vs, busy, brk;
  } exp_t;

  exp_t sb[$];
  exp_t mx;
  int   n_cmp = 0, n_err = 0;
  int   exp_fn = 0, exp_bc = 0, hold_line = 0;
  bit   first = 1'b1, in_active = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic exp_t mk(int l, int f, bit d, bit v, bit b, bit k, int c);
    exp_t x;
    x.line = l; x.fnum = f; x.done = d; x.vs = v; x.busy = b; x.brk = k; x.bcnt = c;
    return x;
  endfunction

  task automatic step(bit r, bit e, bit fs, bit ld, exp_t x);
    @(negedge mclk);
    mrst = r; en = e; frame_start = fs; line_done = ld;
    sb.push_back(x);
  endtask

  task automatic idle();
    step(0, 1, 0, 0, mk(hold_line, exp_fn, 0, 0, 0, 0, exp_bc));
  endtask

  // Start a frame of h lines (vsync delay v) and write n lines one per cycle.
  task automatic frame(int h, int v, int n, bit ld_at_start = 1'b0);
    int nf, tgt;
    bit brk;
    brk = in_active;
    if (sfb || first || exp_fn >= int'(last_frame_number)) nf = 0;
    else nf = exp_fn + 1;
    exp_fn = nf;
    first  = 1'b0;
    if (brk && exp_bc < 255) exp_bc++;
    tgt = (v < h) ? v : h;
    frame_height = FHB'(h);
    vsync_delay  = FHB'(v);
    step(0, 1, 1, ld_at_start, mk(0, nf, 0, tgt == 0, 1, brk, exp_bc));
    for (int i = 1; i <= n && i <= h; i++)
      step(0, 1, 0, 1, mk(i, nf, 0, i == tgt, 1, 0, exp_bc));
    if (n >= h) begin
      step(0, 1, 0, 0, mk(h, nf, 1, 0, 0, 0, exp_bc));
      in_active = 1'b0;
      hold_line = h;
    end else begin
      in_active = 1'b1;
      hold_line = n;
    end
  endtask

  task automatic restart_model(int bc);
    exp_bc = bc; exp_fn = 0; first = 1'b1; in_active = 1'b0; hold_line = 0;
  endtask

  always @(posedge mclk) begin
    #1;
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      chk("line_unfinished", 32'(line_unfinished), mx.line);
      chk("frame_number",    32'(frame_number),    mx.fnum);
      chk("frame_done",      32'(frame_done),      32'(mx.done));
      chk("vsync_late",      32'(vsync_late),      32'(mx.vs));
      chk("frame_busy",      32'(frame_busy),      32'(mx.busy));
      chk("broken_frame",    32'(broken_frame),    32'(mx.brk));
      chk("broken_count",    32'(broken_count),    mx.bcnt);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, including reset overriding active inputs
    step(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    step(1, 1, 1, 1, mk(0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    idle();
    // basic frame: 4 lines, vsync after 2
    frame(4, 2, 4); idle();
    // back-to-back frames with wrap at last_frame_number=2
    frame(3, 1, 3); frame(3, 1, 3); frame(3, 1, 3); idle();
    // abort after 2 of 4 lines
    frame(4, 2, 2); frame(4, 2, 4); idle();
    // zero-height frame and vsync delay beyond the frame
    frame(0, 0, 0); frame(4, 9, 4); idle();
    // last line_done coincident with frame_start is ignored
    frame(4, 2, 3); frame(4, 2, 4, 1'b1); idle();
    // single frame buffer holds number at 0
    sfb = 1'b1;
    repeat (3) frame(2, 1, 2);
    sfb = 1'b0;
    frame(2, 1, 2); idle();
    // en dropped mid-frame; count retained until en rises
    frame(4, 2, 2);
    step(0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, exp_bc));
    step(0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, exp_bc));
    step(0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, exp_bc));
    restart_model(0);
    step(0, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0));
    idle();
    frame(2, 0, 2);
    // reset mid-frame
    frame(4, 2, 1);
    step(1, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0));
    restart_model(0);
    step(0, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0));
    idle();
    frame(1, 1, 1);
    // broken_count saturation
    repeat (300) frame(3, 1, 1);
    frame(3, 1, 3); idle();
    repeat (3) @(negedge mclk);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
